aes_block_loader: RTL and testbench
===================================

Name: aes_block_loader

Overview:
- Byte-serial input front end for the AES datapath: the reader side of the byte path that the top level currently only writes out, one byte at a time, to the seven-segment display.
- Accepts bytes over a valid/ready handshake and assembles them into a 128-bit block, first byte in the most significant position.
- Presents the completed block to the encrypt/decrypt cores over a second valid/ready handshake. This replaces the hard-wired fixed message.

Parameters:
- BLOCK_BYTES, 16, bytes per block; block width is 8*BLOCK_BYTES. Only 16 is supported.
- TIMEOUT_CYCLES, 255, idle cycles allowed inside a partial block before it is discarded. Used only with BLOCK_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  byte present on in_data
- in_data  input  8  input byte
- in_last  input  1  marks the final byte of a message; qualified by in_valid
- in_ready  output  1  loader can accept a byte
- blk_valid  output  1  assembled block available
- blk_ready  input  1  consumer takes the block
- blk_data  output  128  assembled block; byte k occupies bits [127-8k -: 8]
- blk_len  output  5  number of real bytes in the block, 1..16
- blk_short  output  1  block ended early by in_last; trailing bytes are zero-padded
- err_timeout  output  1  one-cycle pulse when a partial block is discarded

Behaviour:
- Reset state (synchronous, active-high):
  - FSM to FILL; byte counter 0; shift register 0.
  - Outputs: blk_valid=0, blk_data=0, blk_len=0, blk_short=0, err_timeout=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Bytes presented while reset is high are ignored.
- States:
  - FILL: in_ready=1, blk_valid=0.
  - FULL: in_ready=0, blk_valid=1.
- in_ready is decoded combinationally from the state register only; it never depends on in_valid.
- Accept rule: a byte is taken on a rising clk edge when in_valid && in_ready.
  - Byte number cnt (0-based) is written to bits [127-8*cnt -: 8].
  - cnt then increments.
- FILL to FULL transition happens on the same edge that accepts either of:
  - the 16th byte (cnt==15), or
  - any byte with in_last=1.
- On that transition:
  - blk_data takes the register contents including the new byte; unfilled bytes are 0.
  - blk_len = cnt+1.
  - blk_short = 1 if and only if cnt<15.
  - blk_valid rises on the next cycle. Latency: last byte accepted to blk_valid high is 1 cycle.
- in_last on the 16th byte: normal full block, blk_short=0.
- FULL state:
  - blk_data, blk_len and blk_short are held stable while blk_ready=0.
  - On blk_valid && blk_ready: return to FILL, clear cnt and the shift register, blk_valid=0 next cycle.
  - blk_data may keep its old value after handoff; consumers qualify it with blk_valid.
- No bypass. A byte cannot be accepted in the same cycle as a block handoff, so minimum spacing is 17 cycles per 16-byte block.
- blk_ready is ignored in FILL.
- in_valid is ignored in FULL; the upstream source must hold its byte until in_ready returns.
- Counter never wraps past 15; cnt==15 always forces FULL.
- Reset mid-fill or mid-FULL discards the partial or pending block with no output pulse.

Optional Feature:
- Macro: BLOCK_TIMEOUT_EN.
- Defined:
  - An idle counter runs in FILL while cnt>0 and no byte is accepted. It clears on every accept and whenever cnt==0.
  - When the idle counter reaches TIMEOUT_CYCLES: cnt and the shift register clear, and err_timeout pulses high for exactly 1 cycle.
  - The state remains FILL.
  - An accept in the same cycle the limit is reached takes priority: no timeout, and the byte is stored.
- Not defined: no idle counter is built, err_timeout is tied to 0, and a partial block waits indefinitely.

Test Plan:
- Full block, back-to-back: bytes 0x00,0x11,...,0xff, in_valid held high, blk_ready=1 -> one cycle after the 16th accept: blk_valid=1, blk_data=128'h00112233445566778899aabbccddeeff, blk_len=16, blk_short=0; in_ready=0 for exactly 1 cycle.
- Backpressure: same block with blk_ready=0 for 10 cycles -> blk_data and blk_valid stable, in_ready=0 throughout; handoff on the cycle blk_ready rises, in_ready=1 on the next cycle.
- Short block: bytes 0xAA,0xBB,0xCC with in_last on 0xCC -> blk_data=128'hAABBCC00...00 (13 zero bytes), blk_len=3, blk_short=1.
- Source throttling and reset: in_valid toggled every other cycle, then reset asserted after byte 7 -> next block starts at byte 0 and blk_data contains only post-reset bytes.
- Timeout (BLOCK_TIMEOUT_EN, TIMEOUT_CYCLES=8): 5 bytes, then idle -> err_timeout high exactly 8 idle cycles later for 1 cycle, no blk_valid; the next 16 bytes form a clean block. Without the macro: no pulse, and the block completes after 11 more bytes.
- Boundary: the 16th byte arrives exactly on the timeout-limit cycle -> accepted, err_timeout stays 0, blk_valid rises next cycle.

Source files
------------

// File: rtl/aes_block_loader.sv
// Byte-serial loader: assembles 16 bytes (first byte in the MSBs) into a block for the AES cores.
// Optional macro BLOCK_TIMEOUT_EN discards a partial block after TIMEOUT_CYCLES idle cycles.
module aes_block_loader #(
  parameter int BLOCK_BYTES    = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [127:0] blk_data,
  output logic [4:0]   blk_len,
  output logic         blk_short,
  output logic         err_timeout
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

  if (BLOCK_BYTES != 16) begin : g_bad_block_bytes
    $error("aes_block_loader: only BLOCK_BYTES=16 is supported");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("aes_block_loader: TIMEOUT_CYCLES must be at least 1");
  end

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   shift_q, shift_d;
  logic [127:0]   blk_data_q, blk_data_d;
  logic [4:0]     blk_len_q, blk_len_d;
  logic           blk_short_q, blk_short_d;
  logic           accept;
  logic [127:0]   merged;

`ifdef BLOCK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              err_q, err_d;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == FULL);
  assign blk_data  = blk_data_q;
  assign blk_len   = blk_len_q;
  assign blk_short = blk_short_q;
  assign accept    = in_valid && in_ready;
  // Unfilled byte lanes of shift_q are always zero, so OR-ing the new byte in is enough.
  assign merged    = shift_q | ({in_data, 120'd0} >> {cnt_q, 3'b000});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    blk_data_d  = blk_data_q;
    blk_len_d   = blk_len_q;
    blk_short_d = blk_short_q;
`ifdef BLOCK_TIMEOUT_EN
    idle_d      = idle_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      FILL: begin
        if (accept) begin
          if (cnt_q == LAST_IDX || in_last) begin
            state_d     = FULL;
            blk_data_d  = merged;
            blk_len_d   = {1'b0, cnt_q} + 5'd1;
            blk_short_d = (cnt_q != LAST_IDX);
          end else begin
            cnt_d   = cnt_q + 4'd1;
            shift_d = merged;
          end
        end
`ifdef BLOCK_TIMEOUT_EN
        // An accept on the limit cycle wins over the timeout.
        if (accept || cnt_q == 4'd0) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LIMIT) begin
          idle_d  = '0;
          cnt_d   = 4'd0;
          shift_d = '0;
          err_d   = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
      end
      FULL: begin
        if (blk_ready) begin
          state_d = FILL;
          cnt_d   = 4'd0;
          shift_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      cnt_q       <= 4'd0;
      shift_q     <= '0;
      blk_data_q  <= '0;
      blk_len_q   <= 5'd0;
      blk_short_q <= 1'b0;
`ifdef BLOCK_TIMEOUT_EN
      idle_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      blk_data_q  <= blk_data_d;
      blk_len_q   <= blk_len_d;
      blk_short_q <= blk_short_d;
`ifdef BLOCK_TIMEOUT_EN
      idle_q      <= idle_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Scoreboard bench for aes_block_loader: expected blocks are queued by stimulus, popped by a monitor on handoff.
module tb_aes_block_loader;

  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   len;
    logic         short_blk;
  } blk_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         blk_valid;
  logic         blk_ready = 1'b1;
  logic [127:0] blk_data;
  logic [4:0]   blk_len;
  logic         blk_short;
  logic         err_timeout;

  int   checks = 0;
  int   errors = 0;
  logic err_window = 1'b0;
  blk_t exp_q[$];

  always #5 clk = ~clk;

  aes_block_loader #(.BLOCK_BYTES(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_len(blk_len), .blk_short(blk_short), .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare on every block handoff.
  always @(negedge clk) begin
    if (!reset && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block", blk_data, 128'h0);
      end else begin
        blk_t e;
        e = exp_q.pop_front();
        chk("blk_data", blk_data, e.data);
        chk("blk_len", 128'(blk_len), 128'(e.len));
        chk("blk_short", 128'(blk_short), 128'(e.short_blk));
      end
    end
    if (!reset && err_timeout && !err_window)
      chk("err_unexpected", 128'(err_timeout), 128'h0);
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout byte=%h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
  endtask

  task automatic push_exp(input logic [127:0] d, input logic [4:0] l, input logic s);
    blk_t e;
    e.data = d;
    e.len = l;
    e.short_blk = s;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset with a byte presented: must be ignored.
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'h1);
    chk("rst_blk_valid", 128'(blk_valid), 128'h0);
    chk("rst_blk_data", blk_data, 128'h0);
    chk("rst_blk_len", 128'(blk_len), 128'h0);
    chk("rst_blk_short", 128'(blk_short), 128'h0);
    chk("rst_err", 128'(err_timeout), 128'h0);
    @(posedge clk);
    #1;

    // Full block back-to-back with blk_ready=1.
    push_exp(128'h00112233445566778899aabbccddeeff, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 1'b0);
    @(negedge clk);
    chk("full_valid", 128'(blk_valid), 128'h1);
    chk("full_in_ready_low", 128'(in_ready), 128'h0);
    @(negedge clk);
    chk("full_in_ready_back", 128'(in_ready), 128'h1);
    chk("full_valid_drop", 128'(blk_valid), 128'h0);
    @(posedge clk);
    #1;

    // Backpressure: hold blk_ready low for 10 cycles.
    blk_ready = 1'b0;
    push_exp(128'h00112233445566778899aabbccddeeff, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h5a;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 128'(blk_valid), 128'h1);
      chk("bp_in_ready", 128'(in_ready), 128'h0);
      chk("bp_data", blk_data, 128'h00112233445566778899aabbccddeeff);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk);
    #1;
    blk_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", 128'(in_ready), 128'h1);
    chk("bp_valid_after", 128'(blk_valid), 128'h0);
    @(posedge clk);
    #1;

    // Short block.
    push_exp({24'haabbcc, 104'h0}, 5'd3, 1'b1);
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    send_byte(8'hcc, 1'b1);
    @(negedge clk);
    chk("short_valid", 128'(blk_valid), 128'h1);
    @(posedge clk);
    #1;

    // Throttled source, reset after byte 7.
    for (int i = 1; i <= 7; i++) begin
      send_byte(8'(8'h50 + i), 1'b0);
      @(posedge clk);
      #1;
    end
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    push_exp({32'he1e2e3e4, 96'h0}, 5'd4, 1'b1);
    send_byte(8'he1, 1'b0);
    send_byte(8'he2, 1'b0);
    send_byte(8'he3, 1'b0);
    send_byte(8'he4, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Idle gap after 5 bytes.
    err_window = 1'b1;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
`ifdef BLOCK_TIMEOUT_EN
      chk($sformatf("tmo_err_%0d", i), 128'(err_timeout), 128'((i == 9) ? 1 : 0));
`else
      chk($sformatf("tmo_err_%0d", i), 128'(err_timeout), 128'h0);
`endif
      chk("tmo_no_valid", 128'(blk_valid), 128'h0);
    end
    err_window = 1'b0;
    @(posedge clk);
    #1;
`ifdef BLOCK_TIMEOUT_EN
    push_exp(128'h202122232425262728292a2b2c2d2e2f, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b0);
`else
    push_exp(128'h0102030405060708090a0b0c0d0e0f10, 5'd16, 1'b0);
    for (int i = 6; i <= 16; i++) send_byte(8'(i), 1'b0);
`endif
    repeat (2) @(posedge clk);
    #1;

    // 16th byte lands on the timeout-limit edge.
    push_exp(128'h808182838485868788898a8b8c8d8e8f, 5'd16, 1'b0);
    for (int i = 0; i < 15; i++) send_byte(8'(8'h80 + i), 1'b0);
    repeat (7) @(posedge clk);
    #1;
    send_byte(8'h8f, 1'b0);
    @(negedge clk);
    chk("bnd_valid", 128'(blk_valid), 128'h1);
    chk("bnd_err", 128'(err_timeout), 128'h0);
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

endmodule
